// File: rtl/aemb2_dwb_lsu.sv
// AEMB2 data-bus load/store unit: one Wishbone cycle per ld/st, byte-lane steering, pipeline stall.
// Optional bus watchdog enabled by defining AEMB_DWB_WDT_EN (adds dwb_tmo_o).
module aemb2_dwb_lsu #(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_WDT = 255
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                dena,
  input  logic [5:0]          opc_of,
  input  logic [31:0]         opd_of,
  input  logic [29:0]         mem_ex,
  input  logic [1:0]          mof_ex,
  output logic [AEMB_DWB-1:2] dwb_adr_o,
  output logic [31:0]         dwb_dat_o,
  output logic [3:0]          dwb_sel_o,
  output logic                dwb_wre_o,
  output logic                dwb_stb_o,
  output logic                dwb_cyc_o,
  input  logic [31:0]         dwb_dat_i,
  input  logic                dwb_ack_i,
`ifdef AEMB_DWB_WDT_EN
  output logic                dwb_tmo_o,
`endif
  output logic                dwb_fb,
  output logic [31:0]         dwb_mx
);

  localparam int AW = AEMB_DWB - 2;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        ldst_of;
  logic [31:0] st_rep;

  logic        cmd_valid;
  logic        cmd_store;
  logic [1:0]  cmd_size;
  logic [31:0] st_dat;
  logic        rdone;

  logic        issue;
  logic        bus_end;
  logic        wdt_hit;
  logic [3:0]  sel_nxt;
  logic [1:0]  mof_bus;
  logic [31:0] ld_val;

  // Any 6'b11xxxx opcode is a transfer; size code 3 is treated as a no-op.
  always_comb begin
    ldst_of = 1'b0;
    casez (opc_of)
      6'b11????: ldst_of = (opc_of[1:0] != 2'b11);
      default:   ldst_of = 1'b0;
    endcase
  end

  always_comb begin
    case (opc_of[1:0])
      2'd0:    st_rep = {4{opd_of[7:0]}};
      2'd1:    st_rep = {2{opd_of[15:0]}};
      default: st_rep = opd_of;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      cmd_valid <= 1'b0;
      cmd_store <= 1'b0;
      cmd_size  <= 2'd0;
      st_dat    <= 32'h0;
    end else if (dena) begin
      cmd_valid <= ldst_of;
      cmd_store <= opc_of[2];
      cmd_size  <= opc_of[1:0];
      st_dat    <= st_rep;
    end
  end

  // A new command always takes precedence over completion of the old one.
  always_ff @(posedge gclk) begin
    if (grst) begin
      rdone <= 1'b0;
    end else if (dena) begin
      rdone <= 1'b0;
    end else if (bus_end) begin
      rdone <= 1'b1;
    end
  end

  assign dwb_fb = !(cmd_valid & !rdone);

  always_comb begin
    case (cmd_size)
      2'd0:    sel_nxt = 4'b1000 >> mof_ex;
      2'd1:    sel_nxt = mof_ex[1] ? 4'b0011 : 4'b1100;
      default: sel_nxt = 4'b1111;
    endcase
  end

  // Big-endian lane selection: offset 0 is bits 31:24.
  always_comb begin
    ld_val = dwb_dat_i;
    case (cmd_size)
      2'd0: begin
        case (mof_bus)
          2'd0:    ld_val = {24'h0, dwb_dat_i[31:24]};
          2'd1:    ld_val = {24'h0, dwb_dat_i[23:16]};
          2'd2:    ld_val = {24'h0, dwb_dat_i[15:8]};
          default: ld_val = {24'h0, dwb_dat_i[7:0]};
        endcase
      end
      2'd1:    ld_val = mof_bus[1] ? {16'h0, dwb_dat_i[15:0]} : {16'h0, dwb_dat_i[31:16]};
      default: ld_val = dwb_dat_i;
    endcase
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    bus_end   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && !rdone) begin
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dwb_ack_i || wdt_hit) begin
          bus_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state     <= IDLE;
      dwb_cyc_o <= 1'b0;
      dwb_stb_o <= 1'b0;
      dwb_wre_o <= 1'b0;
      dwb_sel_o <= 4'h0;
      dwb_adr_o <= '0;
      dwb_dat_o <= 32'h0;
      mof_bus   <= 2'd0;
      dwb_mx    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        dwb_cyc_o <= 1'b1;
        dwb_stb_o <= 1'b1;
        dwb_wre_o <= cmd_store;
        dwb_sel_o <= sel_nxt;
        dwb_adr_o <= AW'(mem_ex);
        dwb_dat_o <= st_dat;
        mof_bus   <= mof_ex;
      end else if (bus_end) begin
        dwb_cyc_o <= 1'b0;
        dwb_stb_o <= 1'b0;
        dwb_wre_o <= 1'b0;
        dwb_sel_o <= 4'h0;
        if (!cmd_store) begin
          dwb_mx <= dwb_ack_i ? ld_val : 32'h0;
        end
      end
    end
  end

`ifdef AEMB_DWB_WDT_EN
  localparam logic [7:0] WDT_LAST = 8'(AEMB_WDT - 1);

  logic [7:0] wdt_cnt;

  // An ack in the limit cycle wins, so only an unacknowledged limit is a timeout.
  assign wdt_hit = (state == BUSY) && (wdt_cnt == WDT_LAST);

  always_ff @(posedge gclk) begin
    if (grst) begin
      wdt_cnt   <= 8'd0;
      dwb_tmo_o <= 1'b0;
    end else begin
      if (issue) begin
        wdt_cnt <= 8'd0;
      end else if (state == BUSY && !dwb_ack_i) begin
        wdt_cnt <= wdt_cnt + 8'd1;
      end
      if (wdt_hit && !dwb_ack_i) begin
        dwb_tmo_o <= 1'b1;
      end
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

endmodule
